fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, one-cycle memory read, small
// {pc,insn} buffer toward decode, redirect flush with misalign pulse.
// Ports: clk, rst (async low); redirect_valid_i/redirect_pc_i;
// insn_ready_i; mem_data_i in, mem_addr_o/mem_read_en_o out;
// insn_valid_o/insn_o/insn_pc_o head of buffer; misaligned_o pulse.
module fetch_unit #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h01000000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  input  logic              insn_ready_i,
  input  logic [DWIDTH-1:0] mem_data_i,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic              mem_read_en_o,
  output logic              insn_valid_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic [AWIDTH-1:0] insn_pc_o,
  output logic              misaligned_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
  } entry_t;

  entry_t          fifo_q [FIFO_DEPTH];
  entry_t          fifo_d [FIFO_DEPTH];
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            mis_q, mis_d;

  logic pop;
  logic push_ok;
  logic rd_en;
  entry_t head;

  assign head          = fifo_q[rd_ptr_q];
  assign insn_valid_o  = (count_q != '0);
  assign pop           = insn_valid_o && insn_ready_i;
  assign push_ok       = (count_q < DEPTH_C) || pop;
  // count is already 0 during reset, so the reset level gates the read.
  assign rd_en         = push_ok && !redirect_valid_i && rst;
  assign mem_read_en_o = rd_en;
  assign mem_addr_o    = pc_q;
  assign insn_o        = insn_valid_o ? head.insn : '0;
  assign insn_pc_o     = insn_valid_o ? head.pc : '0;
  assign misaligned_o  = mis_q;

  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    fifo_d   = fifo_q;
    mis_d    = 1'b0;
    unique case (1'b1)
      redirect_valid_i: begin
        pc_d     = {redirect_pc_i[AWIDTH-1:2], 2'b00};
        count_d  = '0;
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        mis_d    = |redirect_pc_i[1:0];
      end
      default: begin
        if (rd_en) begin
          fifo_d[wr_ptr_q] = '{pc: pc_q, insn: mem_data_i};
          wr_ptr_d = wr_ptr_q + PW'(1);
          pc_d     = pc_q + AWIDTH'(4);
        end
        if (pop) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(rd_en) - CW'(pop);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= BASE_ADDR;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      mis_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      mis_q    <= mis_d;
      fifo_q   <= fifo_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic,
// compared each cycle against a queue-based reference model.
module tb_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [31:0] BASE = 32'h01000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        insn_ready_i = 1'b0;
  logic [31:0] mem_data_i;
  logic [31:0] mem_addr_o;
  logic        mem_read_en_o;
  logic        insn_valid_o;
  logic [31:0] insn_o;
  logic [31:0] insn_pc_o;
  logic        misaligned_o;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  logic        m_mis;

  function automatic logic [31:0] mw(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  assign mem_data_i = mw(mem_addr_o);

  always #5 clk = ~clk;

  fetch_unit #(
    .AWIDTH(32), .DWIDTH(32), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .insn_ready_i(insn_ready_i), .mem_data_i(mem_data_i),
    .mem_addr_o(mem_addr_o), .mem_read_en_o(mem_read_en_o),
    .insn_valid_o(insn_valid_o), .insn_o(insn_o),
    .insn_pc_o(insn_pc_o), .misaligned_o(misaligned_o)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    q.delete();
    m_pc  = BASE;
    m_mis = 1'b0;
  endtask

  task automatic check_reset_outs();
    check("rst_valid", 32'(insn_valid_o), 32'd0);
    check("rst_insn", insn_o, 32'd0);
    check("rst_pc", insn_pc_o, 32'd0);
    check("rst_ren", 32'(mem_read_en_o), 32'd0);
    check("rst_mis", 32'(misaligned_o), 32'd0);
    check("rst_addr", mem_addr_o, BASE);
  endtask

  // Called just after a rising edge; releases rst 1 time unit after the next one.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check_reset_outs();
    mreset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic drive(input logic rv, input logic [31:0] rpc,
                       input logic rdy);
    logic v;
    logic ren;
    redirect_valid_i = rv;
    redirect_pc_i    = rpc;
    insn_ready_i     = rdy;
    @(negedge clk);
    v   = (q.size() != 0);
    ren = ((q.size() < DEPTH) || (v && rdy)) && !rv;
    check("valid", 32'(insn_valid_o), 32'(v));
    check("insn", insn_o, v ? q[0].insn : 32'h0);
    check("insn_pc", insn_pc_o, v ? q[0].pc : 32'h0);
    check("addr", mem_addr_o, m_pc);
    check("ren", 32'(mem_read_en_o), 32'(ren));
    check("mis", 32'(misaligned_o), 32'(m_mis));
  endtask

  task automatic tick();
    logic v;
    logic pop;
    logic ren;
    ent_t e;
    v   = (q.size() != 0);
    pop = v && insn_ready_i;
    ren = ((q.size() < DEPTH) || pop) && !redirect_valid_i;
    @(posedge clk);
    if (redirect_valid_i) begin
      q.delete();
      m_pc  = redirect_pc_i & 32'hFFFFFFFC;
      m_mis = |redirect_pc_i[1:0];
    end else begin
      m_mis = 1'b0;
      if (pop) void'(q.pop_front());
      if (ren) begin
        e.pc   = m_pc;
        e.insn = mw(m_pc);
        q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  task automatic step(input logic rv, input logic [31:0] rpc,
                      input logic rdy);
    drive(rv, rpc, rdy);
    tick();
  endtask

  initial begin
    logic [31:0] rpc;
    logic        rv;
    mreset();
    #1;
    do_reset();

    // Streaming A, B, C with decode always ready.
    drive(0, 0, 1);
    check("first_addr", mem_addr_o, BASE);
    tick();
    drive(0, 0, 1);
    check("pc_A", insn_pc_o, BASE);
    check("insn_A", insn_o, mw(BASE));
    tick();
    drive(0, 0, 1);
    check("pc_B", insn_pc_o, BASE + 32'd4);
    tick();
    drive(0, 0, 1);
    check("pc_C", insn_pc_o, BASE + 32'd8);
    tick();

    // Backpressure: two fetches then stall at 0x01000008.
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    drive(0, 0, 0);
    check("stall_addr", mem_addr_o, BASE + 32'd8);
    check("stall_ren", 32'(mem_read_en_o), 32'd0);
    tick();
    drive(0, 0, 1);
    check("rel_A", insn_pc_o, BASE);
    tick();
    drive(0, 0, 1);
    check("rel_B", insn_pc_o, BASE + 32'd4);
    tick();
    drive(0, 0, 1);
    check("rel_C", insn_pc_o, BASE + 32'd8);
    tick();

    // Redirect while full and ready.
    step(0, 0, 0);
    step(0, 0, 0);
    drive(1, 32'h01000100, 1);
    tick();
    drive(0, 0, 1);
    check("redir_empty", 32'(insn_valid_o), 32'd0);
    tick();
    drive(0, 0, 1);
    check("redir_pc", insn_pc_o, 32'h01000100);
    tick();

    // Misaligned target.
    drive(1, 32'h01000102, 1);
    tick();
    drive(0, 0, 1);
    check("mis_hi", 32'(misaligned_o), 32'd1);
    check("mis_addr", mem_addr_o, 32'h01000100);
    tick();
    drive(0, 0, 1);
    check("mis_lo", 32'(misaligned_o), 32'd0);
    tick();

    // Address wrap.
    drive(1, 32'hFFFFFFFC, 1);
    tick();
    drive(0, 0, 0);
    check("wrap_top", mem_addr_o, 32'hFFFFFFFC);
    tick();
    drive(0, 0, 0);
    check("wrap_zero", mem_addr_o, 32'h0);
    tick();

    // Redirect held for several cycles.
    for (int i = 0; i < 3; i++) step(1, 32'h00002000 + 32'(i * 8), 1);
    step(0, 0, 1);

    // Asynchronous reset mid-cycle with two buffered entries.
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    drive(0, 0, 0);
    check("pre_rst_full", 32'(insn_valid_o), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outs();
    mreset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(0, 0, 1);
    check("restart_addr", mem_addr_o, BASE);
    tick();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rv  = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 7) == 0) ?
            (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) :
            (BASE | 32'($urandom_range(0, 4095)));
      step(rv, rpc, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
